// File: rtl/trainled_pkg.sv
// rtl/trainled_pkg.sv - shared types and default timing for the TrainLED2 frame encoder
// Contents: state_t (encoder FSM states), PIXEL_BITS, default cell/latch/gap timing,
// and the node idle threshold the latch gap has to clear.
package trainled_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int PIXEL_BITS        = 24;

    localparam int DEF_BIT_CYCLES    = 12;
    localparam int DEF_HIGH_CYCLES   = 4;
    localparam int DEF_DATA_CYCLES   = 4;
    localparam int DEF_LATCH_CYCLES  = 128;
    localparam int DEF_GAP_WARN      = 88;

    // A node treats more than this many consecutive low clocks as end of frame.
    localparam int NODE_IDLE_CYCLES  = 97;

endpackage

// File: rtl/trainled_bit_cell.sv
// rtl/trainled_bit_cell.sv - bit-cell phase counter and phase-to-line-level encoder
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : held high to park the cell at phase 0; counting runs while low
//   data_bit  : bit currently being sent (level of the data phase)
//   line      : combinational line level for the current phase
//   cell_end  : high on the last phase of a running cell
module trainled_bit_cell #(
    parameter int BIT_CYCLES  = 12,
    parameter int HIGH_CYCLES = 4,
    parameter int DATA_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic data_bit,
    output logic line,
    output logic cell_end
);

    localparam int PW = $clog2(BIT_CYCLES);

    logic [PW-1:0] phase;

    assign cell_end = !start && (phase == PW'(BIT_CYCLES - 1));

    // Wrapping inside the cell lets back-to-back cells run with no dead clock.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            phase <= '0;
        end else if (cell_end) begin
            phase <= '0;
        end else begin
            phase <= phase + PW'(1);
        end
    end

    always_comb begin
        line = 1'b0;
        if (!start) begin
            if (phase < PW'(HIGH_CYCLES)) begin
                line = 1'b1;
            end else if (phase < PW'(HIGH_CYCLES + DATA_CYCLES)) begin
                line = data_bit;
            end
        end
    end

endmodule

// File: rtl/trainled_frame_tx.sv
// rtl/trainled_frame_tx.sv - TrainLED2 frame encoder: pixel words in, single-wire din out
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   pix_data    : 24-bit pixel word, sent MSB first ([23:16] lands in the first node's LED3)
//   pix_last    : marks the final pixel of a frame
//   pix_valid   : upstream offers a word
//   pix_ready   : one-entry hold buffer is empty
//   dout        : registered serial line to the first node's din
//   busy        : high unless idle with an empty hold buffer
//   frame_done  : one-cycle pulse on the last latch-gap clock
//   underrun    : one-cycle pulse when a mid-frame gap reaches GAP_WARN clocks
module trainled_frame_tx
    import trainled_pkg::*;
#(
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int HIGH_CYCLES  = DEF_HIGH_CYCLES,
    parameter int DATA_CYCLES  = DEF_DATA_CYCLES,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int GAP_WARN     = DEF_GAP_WARN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIXEL_BITS-1:0] pix_data,
    input  logic                  pix_last,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic                  dout,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun
);

    localparam int LW = $clog2(LATCH_CYCLES);
    localparam int GW = $clog2(GAP_WARN + 1);

    state_t                state, state_next;

    logic [PIXEL_BITS-1:0] hold_data;
    logic                  hold_last;
    logic                  hold_full;

    logic [PIXEL_BITS-1:0] shift_data;
    logic                  shift_last;
    logic [4:0]            bit_idx;

    logic [LW-1:0]         latch_cnt;
    logic [GW-1:0]         gap_cnt;

    logic                  accept;
    logic                  load;
    logic                  cell_start;
    logic                  cell_line;
    logic                  cell_end;
    logic                  pixel_end;
    logic                  frame_done_next;
    logic                  underrun_next;

    assign pix_ready  = !hold_full;
    assign busy       = !((state == IDLE) && !hold_full);
    assign accept     = pix_valid && pix_ready;
    assign cell_start = (state != SHIFT);
    assign pixel_end  = cell_end && (bit_idx == 5'(PIXEL_BITS - 1));

    trainled_bit_cell #(
        .BIT_CYCLES  (BIT_CYCLES),
        .HIGH_CYCLES (HIGH_CYCLES),
        .DATA_CYCLES (DATA_CYCLES)
    ) u_bit_cell (
        .clk      (clk),
        .rst      (rst),
        .start    (cell_start),
        .data_bit (shift_data[PIXEL_BITS-1]),
        .line     (cell_line),
        .cell_end (cell_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        load            = 1'b0;
        frame_done_next = 1'b0;
        underrun_next   = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (pixel_end) begin
                    if (shift_last) begin
                        state_next = LATCH;
                    end else if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (hold_full) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else if (gap_cnt == GW'(GAP_WARN - 1)) begin
                    underrun_next = 1'b1;
                end
            end
            LATCH: begin
                // A word may already sit in the hold; it waits until IDLE.
                if (latch_cnt == LW'(LATCH_CYCLES - 1)) begin
                    frame_done_next = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_full  <= 1'b0;
            shift_data <= '0;
            shift_last <= 1'b0;
            bit_idx    <= '0;
            latch_cnt  <= '0;
            gap_cnt    <= '0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (accept) begin
                hold_data <= pix_data;
                hold_last <= pix_last;
            end
            // A same-cycle write wins, so a read plus refill leaves the hold full.
            if (accept) begin
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (load) begin
                shift_data <= hold_data;
                shift_last <= hold_last;
                bit_idx    <= '0;
            end else if ((state == SHIFT) && cell_end) begin
                shift_data <= shift_data << 1;
                bit_idx    <= bit_idx + 5'd1;
            end

            if ((state == LATCH) && (state_next == LATCH)) begin
                latch_cnt <= latch_cnt + LW'(1);
            end else begin
                latch_cnt <= '0;
            end

            // The gap counter parks at GAP_WARN so a long stall warns only once.
            if ((state == GAP) && (state_next == GAP)) begin
                if (gap_cnt != GW'(GAP_WARN)) begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
            end else begin
                gap_cnt <= '0;
            end

            dout       <= (state == SHIFT) ? cell_line : 1'b0;
            frame_done <= frame_done_next;
            underrun   <= underrun_next;
        end
    end

endmodule

// File: tb/tb_trainled_frame_tx.sv
// tb/tb_trainled_frame_tx.sv - scoreboard bench for trainled_frame_tx with a 3-node chain model
module tb_trainled_frame_tx;
    import trainled_pkg::*;

    localparam int CELL  = DEF_BIT_CYCLES;
    localparam int PIXEL = PIXEL_BITS * DEF_BIT_CYCLES;

    logic        clk;
    logic        rst;
    logic [23:0] pix_data;
    logic        pix_last;
    logic        pix_valid;
    logic        pix_ready;
    logic        dout;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    trainled_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q[$];
    logic [23:0] frame_words[$];
    int          word_starts[$];
    logic [23:0] nodes[3];

    int   cyc = 0;
    int   bit_cnt = 0;
    int   high_len = 0;
    int   low_len = 0;
    int   last_high = 0;
    int   fd_count = 0;
    int   ur_count = 0;
    int   fd_cycle = 0;
    int   last_rise = 0;
    int   partial_drops = 0;
    logic prev = 1'b0;
    logic [23:0] shreg = '0;

    task automatic check(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Chain model: a pulse of HIGH+DATA clocks is a 1, HIGH clocks a 0; a low run
    // longer than the node idle threshold latches words in arrival order.
    task automatic decode_pulse();
        logic b;
        b = (high_len == DEF_HIGH_CYCLES + DEF_DATA_CYCLES);
        check("pulse_width", (high_len == DEF_HIGH_CYCLES) || b, high_len, DEF_HIGH_CYCLES);
        last_high = high_len;
        shreg = {shreg[22:0], b};
        bit_cnt++;
        if (bit_cnt == PIXEL_BITS) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 1'b0, shreg, 0);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("pixel_word", shreg == e, shreg, e);
            end
            frame_words.push_back(shreg);
            bit_cnt = 0;
        end
    endtask

    task automatic node_latch();
        if (bit_cnt != 0) begin
            partial_drops++;
            bit_cnt = 0;
        end
        for (int k = 0; k < 3; k++) begin
            if (k < frame_words.size()) nodes[k] = frame_words[k];
        end
        frame_words.delete();
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            prev     = 1'b0;
            high_len = 0;
            low_len  = 0;
        end else begin
            if (dout) begin
                if (!prev) begin
                    high_len  = 1;
                    last_rise = cyc;
                    if (bit_cnt == 0) word_starts.push_back(cyc);
                end else begin
                    high_len++;
                end
                low_len = 0;
            end else begin
                if (prev) decode_pulse();
                low_len++;
                if (low_len == NODE_IDLE_CYCLES + 1) node_latch();
            end
            if (frame_done) begin
                fd_count++;
                fd_cycle = cyc;
                check("frame_done_gap", low_len == CELL - last_high + DEF_LATCH_CYCLES,
                      low_len, CELL - last_high + DEF_LATCH_CYCLES);
            end
            if (underrun) begin
                ur_count++;
                check("underrun_gap", low_len == CELL - last_high + DEF_GAP_WARN,
                      low_len, CELL - last_high + DEF_GAP_WARN);
            end
            prev = dout;
        end
    end

    // Called just after a negedge; returns just after the negedge following the accept edge.
    task automatic send_pixel(input logic [23:0] d, input logic l, input bit scored, output int acc_cyc);
        int n;
        n = 0;
        pix_data  = d;
        pix_last  = l;
        pix_valid = 1'b1;
        while (!pix_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            check("accept_timeout", 1'b0, n, 0);
            acc_cyc = -1;
        end else begin
            if (scored) exp_q.push_back(d);
            @(negedge clk);
            acc_cyc = cyc;
        end
    endtask

    task automatic wait_fd(input int base, input string name);
        int n;
        n = 0;
        while (fd_count == base && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, fd_count != base, fd_count, base + 1);
    endtask

    initial begin
        int acc;
        int acc_b;
        int base;
        int ur0;
        int n;
        int accs[5];
        logic [23:0] w[2];

        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_data  = '0;
        pix_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dout", dout == 1'b0, dout, 0);
        check("reset_pix_ready", pix_ready == 1'b1, pix_ready, 1);
        check("reset_busy", busy == 1'b0, busy, 0);
        check("reset_frame_done", frame_done == 1'b0, frame_done, 0);
        check("reset_underrun", underrun == 1'b0, underrun, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single pixel frame, latency and latch gap
        word_starts.delete();
        base = fd_count;
        send_pixel(24'h800001, 1'b1, 1'b1, acc);
        pix_valid = 1'b0;
        check("t1_busy", busy == 1'b1, busy, 1);
        wait_fd(base, "t1_frame_done");
        n = (word_starts.size() > 0) ? word_starts[0] - acc : -1;
        check("t1_latency", n == 2, n, 2);
        check("t1_node1", nodes[0] == 24'h800001, nodes[0], 24'h800001);
        check("t1_no_underrun", ur_count == 0, ur_count, 0);
        @(negedge clk);
        check("t1_idle_busy", busy == 1'b0, busy, 0);

        // Back-to-back frame into a 3-node chain
        word_starts.delete();
        base = fd_count;
        send_pixel(24'h123456, 1'b0, 1'b1, acc);
        send_pixel(24'hABCDEF, 1'b0, 1'b1, acc);
        send_pixel(24'h0F0F0F, 1'b1, 1'b1, acc);
        pix_valid = 1'b0;
        wait_fd(base, "t2_frame_done");
        check("t2_node1", nodes[0] == 24'h123456, nodes[0], 24'h123456);
        check("t2_node2", nodes[1] == 24'hABCDEF, nodes[1], 24'hABCDEF);
        check("t2_node3", nodes[2] == 24'h0F0F0F, nodes[2], 24'h0F0F0F);
        for (int i = 1; i < word_starts.size(); i++) begin
            check("t2_period", word_starts[i] - word_starts[i-1] == PIXEL,
                  word_starts[i] - word_starts[i-1], PIXEL);
        end
        check("t2_word_count", word_starts.size() == 3, word_starts.size(), 3);
        check("t2_no_underrun", ur_count == 0, ur_count, 0);

        // Mid-frame stall of 100 clocks beyond the first pixel
        ur0  = ur_count;
        base = fd_count;
        send_pixel(24'($urandom()), 1'b0, 1'b1, acc);
        pix_valid = 1'b0;
        repeat (PIXEL + 100) @(negedge clk);
        send_pixel(24'($urandom()), 1'b1, 1'b1, acc);
        pix_valid = 1'b0;
        wait_fd(base, "t3_frame_done");
        check("t3_underrun_once", ur_count == ur0 + 1, ur_count, ur0 + 1);

        // pix_valid held high for a whole frame
        word_starts.delete();
        base = fd_count;
        for (int i = 0; i < 5; i++) begin
            send_pixel(24'($urandom()), i == 4, 1'b1, accs[i]);
            if (i == 0) check("t4_ready_drop", pix_ready == 1'b0, pix_ready, 0);
        end
        pix_valid = 1'b0;
        wait_fd(base, "t4_frame_done");
        for (int i = 3; i < 5; i++) begin
            check("t4_accept_period", accs[i] - accs[i-1] == PIXEL, accs[i] - accs[i-1], PIXEL);
        end
        for (int i = 1; i < word_starts.size(); i++) begin
            check("t4_period", word_starts[i] - word_starts[i-1] == PIXEL,
                  word_starts[i] - word_starts[i-1], PIXEL);
        end
        check("t4_word_count", word_starts.size() == 5, word_starts.size(), 5);

        // New pixel offered while the latch gap runs
        base = fd_count;
        send_pixel(24'($urandom()), 1'b1, 1'b1, acc);
        pix_valid = 1'b0;
        repeat (300) @(negedge clk);
        send_pixel(24'($urandom()), 1'b1, 1'b1, acc_b);
        pix_valid = 1'b0;
        check("t5_accepted_in_latch", fd_count == base, fd_count, base);
        wait_fd(base, "t5_frame_done_a");
        check("t5_low_during_latch", last_rise < acc_b, last_rise, acc_b);
        n = 0;
        while (last_rise <= fd_cycle && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_rise_after_done", last_rise - fd_cycle == 2, last_rise - fd_cycle, 2);
        wait_fd(base + 1, "t5_frame_done_b");

        // Reset in the middle of bit 10
        send_pixel(24'($urandom()), 1'b1, 1'b0, acc);
        pix_valid = 1'b0;
        n = 0;
        while (!(bit_cnt == 10 && dout) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached_bit10", n < 1000, n, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_dout", dout == 1'b0, dout, 0);
        check("t6_pix_ready", pix_ready == 1'b1, pix_ready, 1);
        check("t6_busy", busy == 1'b0, busy, 0);
        rst = 1'b0;
        repeat (120) @(negedge clk);
        check("t6_partial_dropped", partial_drops == 1, partial_drops, 1);
        base = fd_count;
        w[0] = 24'($urandom());
        w[1] = 24'($urandom());
        send_pixel(w[0], 1'b0, 1'b1, acc);
        send_pixel(w[1], 1'b1, 1'b1, acc);
        pix_valid = 1'b0;
        wait_fd(base, "t6_frame_done");
        check("t6_node1", nodes[0] == w[0], nodes[0], w[0]);
        check("t6_node2", nodes[1] == w[1], nodes[1], w[1]);

        // Random frames with short random spacing
        ur0 = ur_count;
        for (int f = 0; f < 4; f++) begin
            int np;
            logic [23:0] fw[3];
            np   = $urandom_range(1, 3);
            base = fd_count;
            for (int i = 0; i < np; i++) begin
                repeat ($urandom_range(0, 4)) begin
                    pix_valid = 1'b0;
                    @(negedge clk);
                end
                fw[i] = 24'($urandom());
                send_pixel(fw[i], i == np - 1, 1'b1, acc);
            end
            pix_valid = 1'b0;
            wait_fd(base, "t7_frame_done");
            for (int i = 0; i < np; i++) begin
                check("t7_node", nodes[i] == fw[i], nodes[i], fw[i]);
            end
        end
        check("t7_no_underrun", ur_count == ur0, ur_count, ur0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size() == 0, exp_q.size(), 0);
        check("partial_total", partial_drops == 1, partial_drops, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
